blk_sync: RTL
=============

# blk_sync

Front-end timing stage for the block statistics buffer. It takes raw video timing and pixels and produces a registered, region-masked pixel stream. It also generates the `h_save` / `v_save` strobes that mark block boundaries for the downstream `blk_buffer`, so that block accumulation stays aligned to a fixed HBLKS×VBLKS grid of BW×BH-pixel blocks. It also flags malformed lines and frames.

## Interface
Parameters:
- `HBLKS`, 10: blocks per line.
- `VBLKS`, 10: block rows per frame.
- `BW`, 30: block width in pixels.
- `BH`, 30: block height in lines.

Ports:
- `clk_i`, in, 1: pixel clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `vs_i`, in, 1: vertical sync, active-high. A rising edge marks frame start.
- `de_i`, in, 1: input data enable.
- `data_i`, in, 24: pixel `{R,G,B}`.
- `de_o`, out, 1: masked data enable to `blk_buffer.de_i`.
- `wd_o`, out, 24: pixel to `blk_buffer.wd_i`. Zero when `de_o`=0.
- `h_save_o`, out, 1: pulse on the last pixel of each block segment in a line.
- `v_save_o`, out, 1: pulse at the end of each block row.
- `line_err_o`, out, 1: sticky. A line had length ≠ HBLKS·BW.
- `frame_err_o`, out, 1: sticky. A frame ended with line count ≠ VBLKS·BH, or `vs` arrived mid-line.

## Operation
- Counters:
  - `px` counts 0..BW-1.
  - `hb` counts 0..HBLKS-1.
  - `ln` counts 0..BH-1.
  - `vb` counts 0..VBLKS. The value VBLKS means the frame is done and the rest is ignored.
- Frame start (`vs_i` 0→1):
  - Clears `px`, `hb`, `ln`, `vb`.
  - Clears both error flags, then applies this frame's frame check (below).
- Active pixel: `de_i`=1, `vb`<VBLKS and `hb`<HBLKS.
  - The pixel is forwarded (`de_o`=1, `wd_o`=`data_i`).
  - `px` increments.
  - When `px`=BW-1: assert `h_save_o`, set `px`=0, increment `hb`.
- `de_i`=1 outside the grid (`hb`=HBLKS or `vb`=VBLKS): `de_o`=0 and `wd_o`=0.
  - In the `hb`=HBLKS case, set `line_err`.
- End of line (`de_i` 1→0, detected from a registered `de_i`):
  - If `vb`<VBLKS and (`hb`≠HBLKS or `px`≠0): set `line_err`.
  - Clear `px` and `hb`.
  - If `vb`<VBLKS, increment `ln`. When `ln` was BH-1: set `ln`=0, assert `v_save_o`, increment `vb`.
- Frame check at the frame-start cycle: flag `frame_err` if either holds:
  - `vb`≠VBLKS or `ln`≠0;
  - `de_i` is high on the `vs` edge (aborted line).
- Skip the frame check for the first frame after reset.
- Priority: frame start overrides end of line and pixel handling in the same cycle.
  - The aborted line produces no `v_save_o`.
  - An `h_save_o` already registered still issues.
- Strobe shape:
  - `h_save_o` is only ever high together with `de_o`=1.
  - `v_save_o` is only ever high with `de_o`=0.
  - Neither strobe is high for more than 1 consecutive cycle.
- Reset mid-frame: all state returns to reset values. Nothing is emitted until the next `vs_i` rising edge; `de_i` is ignored until then.

## Timing
- All outputs are registered, latency 1 cycle from `de_i`/`data_i`.
- `h_save_o` is coincident with `de_o` of the block's last pixel.
- `v_save_o` is high exactly in the first `de_o`=0 cycle after the last pixel of line BH-1 of a block row. That is the same cycle as the end-of-line detection, i.e. 1 cycle after `de_i` falls.
- Downstream `cls_cnt` relies on this ordering: the v_save for row r precedes every h_save of row r+1. Blanking must therefore be ≥1 cycle; shorter blanking is not supported.
- Reset values:
  - `de_o`, `wd_o`, `h_save_o`, `v_save_o`, `line_err_o`, `frame_err_o` = 0.
  - All counters = 0.
  - Internal armed flag = 0 (waiting for first `vs`).
- Counter widths: `$clog2(BW)`, `$clog2(HBLKS+1)`, `$clog2(BH)`, `$clog2(VBLKS+1)`.

## Structure
- The shared package/header holds the default geometry constants (HBLKS/VBLKS/BW/BH). `blk_buffer` and the top level use the same values.
- One sub-module, `wrap_cnt`, instantiated for each counter:
  - Parameter: MAX.
  - Inputs: `clr`, `inc`.
  - Outputs: `q`, `wrap` (combinational `inc && q==MAX`).
- The edge detectors for `vs` and `de` stay inline.

## Test plan
All scenarios use HBLKS=3, VBLKS=2, BW=4, BH=2; the nominal frame is 4 lines × 12 px.
- **Nominal frame:**
  - `h_save_o` pulses at `de_o` pixel indices 3, 7, 11 on each line: 12 total.
  - `v_save_o` pulses twice, 1 cycle after lines 1 and 3 end.
  - Both error flags stay 0.
- **Long line (14 px) on line 0:**
  - `de_o` is high for 12 cycles only, with 3 `h_save_o` pulses.
  - `line_err_o`=1 and stays 1 until the next `vs` edge.
- **Short line (9 px):**
  - 2 `h_save_o` pulses.
  - `line_err_o`=1.
  - `ln` still advances, so `v_save_o` timing is unchanged.
- **Frame of 6 lines:**
  - Lines 4-5 give `de_o`=0 and no strobes.
  - At the next `vs` edge, `frame_err_o` is set (`ln`=0 but extra lines), because the check also requires an exact line count. The bench asserts `frame_err_o`=1.
- **`vs` rises while `de_i`=1 mid-line 2:**
  - Counters clear.
  - No `v_save_o` for the aborted row.
  - `frame_err_o`=1.
- **`rst_i` pulsed mid-frame:**
  - All outputs go to 0 asynchronously.
  - `de_o` stays 0 despite active `de_i` until the next `vs` rising edge.
  - The following frame is nominal, with no error flags.

Source files
------------

// File: rtl/blk_sync_pkg.sv
// rtl/blk_sync_pkg.sv - shared block-grid geometry and counter width helper
package blk_sync_pkg;

    localparam int HBLKS_DEF = 10;
    localparam int VBLKS_DEF = 10;
    localparam int BW_DEF    = 30;
    localparam int BH_DEF    = 30;
    localparam int PIX_W     = 24;

    // Bits needed to hold 0..max (at least one bit).
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/blk_sync_if.sv
// rtl/blk_sync_if.sv - video timing in / masked pixel stream and strobes out
interface blk_sync_if;
    import blk_sync_pkg::*;

    logic             vs_i;
    logic             de_i;
    logic [PIX_W-1:0] data_i;
    logic             de_o;
    logic [PIX_W-1:0] wd_o;
    logic             h_save_o;
    logic             v_save_o;
    logic             line_err_o;
    logic             frame_err_o;

    modport master (
        output vs_i, de_i, data_i,
        input  de_o, wd_o, h_save_o, v_save_o, line_err_o, frame_err_o
    );

    modport slave (
        input  vs_i, de_i, data_i,
        output de_o, wd_o, h_save_o, v_save_o, line_err_o, frame_err_o
    );
endinterface

// File: rtl/blk_sync_wrap_cnt.sv
// rtl/blk_sync_wrap_cnt.sv - 0..MAX counter with clear priority and wrap flag
module wrap_cnt
    import blk_sync_pkg::*;
#(
    parameter int  MAX = 1,
    localparam int W   = cnt_w(MAX)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         wrap
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    assign wrap = inc && (q_q == W'(MAX));
    assign q    = q_q;

    // Clear beats increment; an increment at MAX rolls back to zero.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (wrap) begin
            q_d = '0;
        end else if (inc) begin
            q_d = q_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/blk_sync.sv
// rtl/blk_sync.sv - region-masked pixel stream with block boundary strobes
module blk_sync
    import blk_sync_pkg::*;
#(
    parameter int HBLKS = HBLKS_DEF,
    parameter int VBLKS = VBLKS_DEF,
    parameter int BW    = BW_DEF,
    parameter int BH    = BH_DEF
) (
    input logic       clk_i,
    input logic       rst_i,
    blk_sync_if.slave bus
);

    localparam int PXW = cnt_w(BW - 1);
    localparam int HBW = cnt_w(HBLKS);
    localparam int LNW = cnt_w(BH - 1);
    localparam int VBW = cnt_w(VBLKS);

    logic [PXW-1:0] px;
    logic [HBW-1:0] hb;
    logic [LNW-1:0] ln;
    logic [VBW-1:0] vb;
    logic           px_wrap, hb_wrap, ln_wrap, vb_wrap;

    logic vs_q, de_q, armed_q, extra_q;
    logic armed_d, extra_d;
    logic de_o_q, de_o_d;
    logic [PIX_W-1:0] wd_q, wd_d;
    logic h_save_q, h_save_d, v_save_q, v_save_d;
    logic line_err_q, line_err_d, frame_err_q, frame_err_d;

    logic frame_start, vb_live, in_grid, pix_act, eol, line_clr, ln_inc;

    // Event decode; a frame start masks line-end and pixel work in that cycle.
    always_comb begin
        frame_start = bus.vs_i && !vs_q;
        vb_live     = (vb < VBW'(VBLKS));
        in_grid     = vb_live && (hb < HBW'(HBLKS));
        pix_act     = armed_q && !frame_start && bus.de_i && in_grid;
        eol         = armed_q && !frame_start && de_q && !bus.de_i;
        line_clr    = frame_start || eol;
        ln_inc      = eol && vb_live;
    end

    wrap_cnt #(.MAX(BW - 1)) u_px (
        .clk_i(clk_i), .rst_i(rst_i), .clr(line_clr), .inc(pix_act),
        .q(px), .wrap(px_wrap)
    );

    wrap_cnt #(.MAX(HBLKS)) u_hb (
        .clk_i(clk_i), .rst_i(rst_i), .clr(line_clr), .inc(px_wrap),
        .q(hb), .wrap(hb_wrap)
    );

    wrap_cnt #(.MAX(BH - 1)) u_ln (
        .clk_i(clk_i), .rst_i(rst_i), .clr(frame_start), .inc(ln_inc),
        .q(ln), .wrap(ln_wrap)
    );

    wrap_cnt #(.MAX(VBLKS)) u_vb (
        .clk_i(clk_i), .rst_i(rst_i), .clr(frame_start), .inc(ln_wrap),
        .q(vb), .wrap(vb_wrap)
    );

    // hb and vb increments are gated below their MAX, so they never wrap.
    logic unused_wraps;
    assign unused_wraps = hb_wrap | vb_wrap;

    // Next output values, sticky error flags and frame bookkeeping.
    always_comb begin
        de_o_d      = pix_act;
        wd_d        = pix_act ? bus.data_i : '0;
        h_save_d    = px_wrap;
        v_save_d    = ln_wrap;
        armed_d     = armed_q || frame_start;
        extra_d     = extra_q;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        if (frame_start) begin
            extra_d     = 1'b0;
            line_err_d  = 1'b0;
            frame_err_d = armed_q && ((vb != VBW'(VBLKS)) || (ln != '0) ||
                                      extra_q || bus.de_i);
        end else begin
            if (armed_q && bus.de_i && vb_live && (hb == HBW'(HBLKS))) begin
                line_err_d = 1'b1;
            end
            if (eol && vb_live && ((hb != HBW'(HBLKS)) || (px != '0))) begin
                line_err_d = 1'b1;
            end
            // Lines after the grid is full still make the line count wrong.
            if (eol && !vb_live) begin
                extra_d = 1'b1;
            end
        end
    end

    // Output, edge-detect and flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            armed_q     <= 1'b0;
            extra_q     <= 1'b0;
            de_o_q      <= 1'b0;
            wd_q        <= '0;
            h_save_q    <= 1'b0;
            v_save_q    <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            vs_q        <= bus.vs_i;
            de_q        <= bus.de_i;
            armed_q     <= armed_d;
            extra_q     <= extra_d;
            de_o_q      <= de_o_d;
            wd_q        <= wd_d;
            h_save_q    <= h_save_d;
            v_save_q    <= v_save_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.de_o        = de_o_q;
    assign bus.wd_o        = wd_q;
    assign bus.h_save_o    = h_save_q;
    assign bus.v_save_o    = v_save_q;
    assign bus.line_err_o  = line_err_q;
    assign bus.frame_err_o = frame_err_q;

endmodule
